frame_accumulator_par: RTL and testbench

Parametrised streaming accumulator that sums fixed-length frames of unsigned samples using LANES parallel partial-sum registers, then reduces them to one result. It is the successor of the fixed 1024-sample accumulator top: width, frame length, lane count and overflow mode are all parameters. It adds a ready/valid handshake on both the input and result sides, plus frame abort. It sits on the processor clock domain, after the bus-side sample source.

---
 rtl/frame_accumulator_par.sv | 233 +++++++++++++++++++++++
 tb/tb_frame_accumulator_par.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_accumulator_par.sv
// -----------------------------------------------------------------------------
// frame_accumulator_par
//
// Streaming frame accumulator. Unsigned samples are summed over frames of
// FRAME_LEN samples using LANES parallel partial-sum registers (sample k of a
// frame goes to lane k mod LANES). When a frame is complete the lanes are
// folded one per cycle into a single total, which is then presented on a
// ready/valid result port. A synchronous clear aborts the frame in progress.
//
// Every add (lane or reduce) is done at RES_W+1 bits. A carry-out sets the
// sticky per-frame overflow flag; with SATURATE=1 the stored value clamps to
// all ones, otherwise it wraps modulo 2^RES_W.
//
// Ports
//   proc_clk   in   1       sole clock, rising edge
//   reset_n    in   1       asynchronous active-low reset
//   clear      in   1       synchronous frame abort (highest priority)
//   in_data    in   DATA_W  sample
//   in_valid   in   1       sample valid
//   in_ready   out  1       block accepts a sample (ACCUM only)
//   res_data   out  RES_W   frame sum
//   res_ovf    out  1       overflow/saturation occurred in this frame
//   res_valid  out  1       result valid
//   res_ready  in   1       result consumer ready
//   busy       out  1       high while reducing or holding a result
//
// Parameter constraints: RES_W >= DATA_W, LANES a power of two >= 1,
// FRAME_LEN a multiple of LANES.
// -----------------------------------------------------------------------------
module frame_accumulator_par #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RES_W     = 32,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned LANES     = 4,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic              proc_clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  // One extra bit so the counter reaches FRAME_LEN without wrapping.
  localparam int unsigned CNT_W = $clog2(FRAME_LEN) + 1;
  // Reduce index runs 0..LANES; the final value is the publish cycle.
  localparam int unsigned RED_W = $clog2(LANES + 1);
  localparam int unsigned SEL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(FRAME_LEN - 1);
  localparam logic [RED_W-1:0] RED_END = RED_W'(LANES);

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_REDUCE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RES_W-1:0]    lane_q [LANES];
  logic [RES_W-1:0]    lane_d [LANES];
  logic [RES_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RED_W-1:0]    red_q, red_d;
  logic                ovf_q, ovf_d;
  logic [RES_W-1:0]    res_data_q, res_data_d;
  logic                res_ovf_q, res_ovf_d;
  logic                res_valid_q, res_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic [SEL_W-1:0]    lane_sel;
  logic [RES_W-1:0]    in_ext;
  logic [RES_W-1:0]    red_lane;
  logic [RES_W:0]      lane_sum;
  logic [RES_W:0]      red_sum;

  // Add with carry kept in the MSB; in saturating mode the low bits clamp to
  // all ones whenever the carry is set.
  function automatic logic [RES_W:0] add_chk(input logic [RES_W-1:0] a,
                                             input logic [RES_W-1:0] b);
    logic [RES_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (SATURATE && s[RES_W]) begin
      s[RES_W-1:0] = '1;
    end
    return s;
  endfunction

  assign in_ext = RES_W'(in_data);

  // LANES is a power of two, so k mod LANES is just the low counter bits.
  generate
    if (LANES == 1) begin : g_sel_one
      assign lane_sel = '0;
    end else begin : g_sel_many
      assign lane_sel = cnt_q[SEL_W-1:0];
    end
  endgenerate

  always_comb begin
    red_lane = '0;
    for (int l = 0; l < LANES; l++) begin
      if (red_q == RED_W'(l)) begin
        red_lane = lane_q[l];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    total_d     = total_q;
    cnt_d       = cnt_q;
    red_d       = red_q;
    ovf_d       = ovf_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;
    lane_sum    = '0;
    red_sum     = '0;

    if (clear) begin
      // Abort wins over everything, including a sample offered this cycle.
      for (int l = 0; l < LANES; l++) begin
        lane_d[l] = '0;
      end
      total_d     = '0;
      cnt_d       = '0;
      red_d       = '0;
      ovf_d       = 1'b0;
      res_valid_d = 1'b0;
      state_d     = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid && in_ready_q) begin
            for (int l = 0; l < LANES; l++) begin
              if (lane_sel == SEL_W'(l)) begin
                lane_sum  = add_chk(lane_q[l], in_ext);
                lane_d[l] = lane_sum[RES_W-1:0];
              end
            end
            ovf_d = ovf_q | lane_sum[RES_W];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_K) begin
              red_d   = '0;
              state_d = ST_REDUCE;
            end
          end
        end

        ST_REDUCE: begin
          if (red_q != RED_END) begin
            red_sum = add_chk(total_q, red_lane);
            total_d = red_sum[RES_W-1:0];
            ovf_d   = ovf_q | red_sum[RES_W];
            red_d   = red_q + RED_W'(1);
          end else begin
            // All lanes folded: publish the total and the sticky flag.
            res_data_d  = total_q;
            res_ovf_d   = ovf_q;
            res_valid_d = 1'b1;
            state_d     = ST_OUTPUT;
          end
        end

        ST_OUTPUT: begin
          if (res_ready) begin
            for (int l = 0; l < LANES; l++) begin
              lane_d[l] = '0;
            end
            total_d     = '0;
            cnt_d       = '0;
            red_d       = '0;
            ovf_d       = 1'b0;
            res_valid_d = 1'b0;
            state_d     = ST_ACCUM;
          end
        end

        default: begin
          state_d = ST_ACCUM;
        end
      endcase
    end
  end

  // Handshake flags are registered from the next state so they line up with
  // the state they describe.
  assign in_ready_d = (state_d == ST_ACCUM);
  assign busy_d     = (state_d != ST_ACCUM);

  always_ff @(posedge proc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ACCUM;
      lane_q      <= '{default: '0};
      total_q     <= '0;
      cnt_q       <= '0;
      red_q       <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      total_q     <= total_d;
      cnt_q       <= cnt_d;
      red_q       <= red_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_frame_accumulator_par.sv
module tb_frame_accumulator_par;

  localparam int NG = 4;  // 0: A (FL8,L4)  1: S0 (wrap)  2: S1 (sat)  3: D (defaults)

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_clear = 0, a_valid = 0, a_rr = 1;
  logic [15:0] a_data = 0;
  logic        a_in_ready, a_res_valid, a_res_ovf, a_busy;
  logic [31:0] a_res_data;

  logic        s_clear = 0, s_valid = 0, s_rr = 1;
  logic [15:0] s_data = 0;
  logic        s0_in_ready, s0_res_valid, s0_res_ovf, s0_busy;
  logic [16:0] s0_res_data;
  logic        s1_in_ready, s1_res_valid, s1_res_ovf, s1_busy;
  logic [16:0] s1_res_data;

  logic        d_clear = 0, d_valid = 0, d_rr = 1;
  logic [15:0] d_data = 0;
  logic        d_in_ready, d_res_valid, d_res_ovf, d_busy;
  logic [31:0] d_res_data;

  frame_accumulator_par #(.DATA_W(16), .RES_W(32), .FRAME_LEN(8), .LANES(4), .SATURATE(1'b0)) u_a (
    .proc_clk(clk), .reset_n(reset_n), .clear(a_clear), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_in_ready), .res_data(a_res_data), .res_ovf(a_res_ovf), .res_valid(a_res_valid),
    .res_ready(a_rr), .busy(a_busy));

  frame_accumulator_par #(.DATA_W(16), .RES_W(17), .FRAME_LEN(4), .LANES(4), .SATURATE(1'b0)) u_s0 (
    .proc_clk(clk), .reset_n(reset_n), .clear(s_clear), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s0_in_ready), .res_data(s0_res_data), .res_ovf(s0_res_ovf), .res_valid(s0_res_valid),
    .res_ready(s_rr), .busy(s0_busy));

  frame_accumulator_par #(.DATA_W(16), .RES_W(17), .FRAME_LEN(4), .LANES(4), .SATURATE(1'b1)) u_s1 (
    .proc_clk(clk), .reset_n(reset_n), .clear(s_clear), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s1_in_ready), .res_data(s1_res_data), .res_ovf(s1_res_ovf), .res_valid(s1_res_valid),
    .res_ready(s_rr), .busy(s1_busy));

  frame_accumulator_par u_d (
    .proc_clk(clk), .reset_n(reset_n), .clear(d_clear), .in_data(d_data), .in_valid(d_valid),
    .in_ready(d_in_ready), .res_data(d_res_data), .res_ovf(d_res_ovf), .res_valid(d_res_valid),
    .res_ready(d_rr), .busy(d_busy));

  logic        o_rdy [NG];
  logic        o_busy[NG];
  logic        o_rv  [NG];
  logic        o_ovf [NG];
  logic [31:0] o_data[NG];

  always_comb begin
    o_rdy[0] = a_in_ready;  o_busy[0] = a_busy;  o_rv[0] = a_res_valid;  o_ovf[0] = a_res_ovf;  o_data[0] = a_res_data;
    o_rdy[1] = s0_in_ready; o_busy[1] = s0_busy; o_rv[1] = s0_res_valid; o_ovf[1] = s0_res_ovf; o_data[1] = 32'(s0_res_data);
    o_rdy[2] = s1_in_ready; o_busy[2] = s1_busy; o_rv[2] = s1_res_valid; o_ovf[2] = s1_res_ovf; o_data[2] = 32'(s1_res_data);
    o_rdy[3] = d_in_ready;  o_busy[3] = d_busy;  o_rv[3] = d_res_valid;  o_ovf[3] = d_res_ovf;  o_data[3] = d_res_data;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int p_fl [NG] = '{8, 4, 4, 1024};
  int p_ln [NG] = '{4, 4, 4, 4};
  int p_rw [NG] = '{32, 17, 17, 32};
  bit p_sat[NG] = '{1'b0, 1'b0, 1'b1, 1'b0};

  longint m_lane[NG][4];
  int     m_cnt [NG];
  bit     m_ovf [NG];
  int     m_wait[NG];   // edges left until the result appears, 0 = none pending
  bit     m_rv  [NG];
  longint m_res [NG];
  bit     m_rovf[NG];
  bit     m_acc [NG];   // a sample was taken on the most recent edge

  function automatic longint madd(int g, longint a, longint b);
    longint mx;
    longint s;
    mx = (longint'(1) << p_rw[g]) - 1;
    s = a + b;
    if (s > mx) begin
      m_ovf[g] = 1'b1;
      s = p_sat[g] ? mx : (s & mx);
    end
    return s;
  endfunction

  function automatic void mzero(int g);
    for (int l = 0; l < 4; l++) m_lane[g][l] = 0;
    m_cnt[g] = 0; m_ovf[g] = 0; m_wait[g] = 0; m_rv[g] = 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit     iv[NG];
    bit     icl[NG];
    bit     irr[NG];
    longint idt[NG];
    longint tot;
    iv  = '{a_valid, s_valid, s_valid, d_valid};
    icl = '{a_clear, s_clear, s_clear, d_clear};
    irr = '{a_rr, s_rr, s_rr, d_rr};
    idt = '{longint'(a_data), longint'(s_data), longint'(s_data), longint'(d_data)};
    for (int g = 0; g < NG; g++) begin
      m_acc[g] = 1'b0;
      if (!reset_n) begin
        mzero(g); m_res[g] = 0; m_rovf[g] = 0;
      end else if (icl[g]) begin
        mzero(g);
      end else if (m_rv[g]) begin
        if (irr[g]) mzero(g);
      end else if (m_wait[g] > 0) begin
        m_wait[g]--;
        if (m_wait[g] == 0) begin
          tot = 0;
          for (int l = 0; l < p_ln[g]; l++) tot = madd(g, tot, m_lane[g][l]);
          m_res[g] = tot; m_rovf[g] = m_ovf[g]; m_rv[g] = 1'b1;
        end
      end else if (iv[g]) begin
        m_acc[g] = 1'b1;
        m_lane[g][m_cnt[g] % p_ln[g]] = madd(g, m_lane[g][m_cnt[g] % p_ln[g]], idt[g]);
        m_cnt[g]++;
        if (m_cnt[g] == p_fl[g]) m_wait[g] = p_ln[g] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NG; g++) begin
      chk($sformatf("g%0d in_ready", g), longint'(o_rdy[g]), longint'(!(m_wait[g] > 0 || m_rv[g])));
      chk($sformatf("g%0d busy", g), longint'(o_busy[g]), longint'(m_wait[g] > 0 || m_rv[g]));
      chk($sformatf("g%0d res_valid", g), longint'(o_rv[g]), longint'(m_rv[g]));
      if (m_rv[g]) begin
        chk($sformatf("g%0d res_data", g), longint'(o_data[g]), m_res[g]);
        chk($sformatf("g%0d res_ovf", g), longint'(o_ovf[g]), longint'(m_rovf[g]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic setv(int g, bit v, logic [15:0] d);
    case (g)
      0: begin a_valid = v; a_data = d; end
      3: begin d_valid = v; d_data = d; end
      default: begin s_valid = v; s_data = d; end
    endcase
  endtask

  task automatic send(int g, logic [15:0] d, int gap = 0);
    int tries;
    if (gap > 0) begin
      setv(g, 1'b0, 16'h0);
      repeat (gap) @(negedge clk);
    end else begin
      @(negedge clk);
    end
    setv(g, 1'b1, d);
    tries = 0;
    do begin
      @(posedge clk); #1;
      tries++;
    end while (!m_acc[g] && tries < 64);
    if (!m_acc[g]) chk($sformatf("g%0d send timeout", g), 0, 1);
  endtask

  task automatic wait_res(int g, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_rv[g] && n < 3000);
    if (!o_rv[g]) chk($sformatf("g%0d result timeout", g), 0, 1);
  endtask

  initial begin
    #200ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    longint sum;
    logic [15:0] v;

    #1 reset_n = 1'b0;
    #21 reset_n = 1'b1;
    @(negedge clk);
    chk("reset a in_ready", longint'(a_in_ready), 1);
    chk("reset a busy", longint'(a_busy), 0);
    chk("reset a res_valid", longint'(a_res_valid), 0);
    chk("reset a res_data", longint'(a_res_data), 0);
    chk("reset a res_ovf", longint'(a_res_ovf), 0);

    // 1: samples 1..8, then eight 2s
    for (int i = 1; i <= 8; i++) send(0, 16'(i));
    v = 16'd2;
    setv(0, 1'b1, v);
    wait_res(0, n);
    chk("t1 latency", n, 5);
    chk("t1 sum", longint'(a_res_data), 36);
    chk("t1 ovf", longint'(a_res_ovf), 0);
    for (int i = 0; i < 8; i++) send(0, 16'd2);
    setv(0, 1'b0, 16'h0);
    wait_res(0, n);
    chk("t1 sum2", longint'(a_res_data), 16);
    @(posedge clk); #1;
    chk("t1 drained", longint'(a_res_valid), 0);

    // 2: back-pressure on the result
    a_rr = 1'b0;
    for (int i = 1; i <= 8; i++) send(0, 16'(i));
    setv(0, 1'b0, 16'h0);
    wait_res(0, n);
    for (int c = 0; c < 6; c++) begin
      chk("t2 held data", longint'(a_res_data), 36);
      chk("t2 in_ready low", longint'(a_in_ready), 0);
      chk("t2 busy high", longint'(a_busy), 1);
      @(posedge clk); #1;
    end
    a_rr = 1'b1;
    @(posedge clk); #1;
    chk("t2 in_ready after take", longint'(a_in_ready), 1);
    chk("t2 res_valid after take", longint'(a_res_valid), 0);

    // 4: clear with a coincident sample
    for (int i = 0; i < 5; i++) send(0, 16'd10);
    @(negedge clk);
    a_clear = 1'b1;
    setv(0, 1'b1, 16'd10);
    @(posedge clk); #1;
    a_clear = 1'b0;
    chk("t4 in_ready after clear", longint'(a_in_ready), 1);
    for (int i = 0; i < 8; i++) send(0, 16'd1);
    setv(0, 1'b0, 16'h0);
    wait_res(0, n);
    chk("t4 sum", longint'(a_res_data), 8);
    chk("t4 ovf", longint'(a_res_ovf), 0);
    @(posedge clk); #1;

    // 3: overflow wrap vs saturate
    for (int i = 0; i < 4; i++) send(1, 16'hFFFF);
    setv(1, 1'b0, 16'h0);
    wait_res(1, n);
    chk("t3 wrap data", longint'(s0_res_data), 64'h1FFFC);
    chk("t3 wrap ovf", longint'(s0_res_ovf), 1);
    chk("t3 sat data", longint'(s1_res_data), 64'h1FFFF);
    chk("t3 sat ovf", longint'(s1_res_ovf), 1);
    @(posedge clk); #1;

    // 5: asynchronous reset during REDUCE
    for (int i = 0; i < 1024; i++) send(3, 16'(i));
    setv(3, 1'b0, 16'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("t5 busy before reset", longint'(d_busy), 1);
    reset_n = 1'b0;
    #1;
    chk("t5 busy async", longint'(d_busy), 0);
    chk("t5 res_valid async", longint'(d_res_valid), 0);
    chk("t5 res_data async", longint'(d_res_data), 0);
    chk("t5 res_ovf async", longint'(d_res_ovf), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t5 no result", longint'(d_res_valid), 0);

    // 6: random full frame with gaps
    sum = 0;
    for (int i = 0; i < 1024; i++) begin
      v = 16'($urandom_range(0, 65535));
      sum += longint'(v);
      send(3, v, int'($urandom_range(0, 2)));
    end
    setv(3, 1'b0, 16'h0);
    wait_res(3, n);
    chk("t6 sum", longint'(d_res_data), sum);
    chk("t6 ovf", longint'(d_res_ovf), 0);
    @(posedge clk); #1;
    chk("t6 drained", longint'(d_res_valid), 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
